// File: rtl/stg_ex_unit.sv
// stg_ex_unit: execute stage -- 24b ALU with Z/N/C/V flags, branch resolution,
// address/AR arithmetic and SR writeback, one registered cycle with stall/flush.
module stg_ex_unit (
  input  logic        iw_clk,
  input  logic        iw_rst,
  input  logic [47:0] iw_pc,
  input  logic [23:0] iw_instr,
  input  logic [7:0]  iw_opc,
  input  logic        iw_sgn_en,
  input  logic        iw_imm_en,
  input  logic [13:0] iw_imm14_val,
  input  logic [11:0] iw_imm12_val,
  input  logic [9:0]  iw_imm10_val,
  input  logic [15:0] iw_imm16_val,
  input  logic [3:0]  iw_cc,
  input  logic [3:0]  iw_tgt_gp,
  input  logic        iw_tgt_gp_we,
  input  logic [1:0]  iw_tgt_sr,
  input  logic        iw_tgt_sr_we,
  input  logic [1:0]  iw_tgt_ar,
  input  logic [3:0]  iw_src_gp,
  input  logic [1:0]  iw_src_ar,
  input  logic [1:0]  iw_src_sr,
  input  logic [23:0] iw_src_gp_val,
  input  logic [23:0] iw_tgt_gp_val,
  input  logic [47:0] iw_src_ar_val,
  input  logic [47:0] iw_tgt_ar_val,
  input  logic [47:0] iw_src_sr_val,
  input  logic [47:0] iw_tgt_sr_val,
  input  logic        iw_flush,
  input  logic        iw_stall,
  output logic [47:0] ow_pc,
  output logic [23:0] ow_instr,
  output logic [7:0]  ow_opc,
  output logic [3:0]  ow_tgt_gp,
  output logic        ow_tgt_gp_we,
  output logic [1:0]  ow_tgt_sr,
  output logic        ow_tgt_sr_we,
  output logic [1:0]  ow_tgt_ar,
  output logic        ow_tgt_ar_we,
  output logic [47:0] ow_addr,
  output logic [23:0] ow_result,
  output logic [47:0] ow_ar_result,
  output logic [47:0] ow_sr_result,
  output logic        ow_branch_taken,
  output logic [47:0] ow_branch_pc
);
  localparam logic [7:0] NOP = 8'h00, MOVUR = 8'h01, MOVUI = 8'h02, MOVSI = 8'h03,
    ADDUR = 8'h04, ADDUI = 8'h05, ADDSI = 8'h06, SUBUR = 8'h07, SUBUI = 8'h08, SUBSI = 8'h09,
    ANDUR = 8'h0a, ANDUI = 8'h0b, ORUR = 8'h0c, ORUI = 8'h0d, XORUR = 8'h0e, XORUI = 8'h0f,
    NOTUR = 8'h10, CMPUR = 8'h11, CMPUI = 8'h12, CMPSI = 8'h13, JCCUI = 8'h14, JCCSI = 8'h15,
    ADDASI = 8'h16;
  localparam logic [1:0] FL = 2'd2;
  localparam logic [3:0] RA = 4'd0, EQ = 4'd1, NE = 4'd2, LT = 4'd3, GE = 4'd4, LTU = 4'd5, GEU = 4'd6;
  logic [3:0] r_fl, fl_in, fl_new;
  logic [23:0] op_a, op_b, res;
  logic [24:0] sum;
  logic [47:0] br_pc;
  logic is_mov, is_add, is_sub, is_cmp, is_and, is_or, is_xor, is_not, is_jcc, is_adda;
  logic arith, fl_set, c, v, cond, r_branch_taken;
  logic unused;
  assign unused = ^{iw_imm16_val, iw_src_gp, iw_src_ar, iw_src_sr_val[47:4]};
  assign is_mov = iw_opc inside {MOVUR, MOVUI, MOVSI};
  assign is_add = iw_opc inside {ADDUR, ADDUI, ADDSI};
  assign is_sub = iw_opc inside {SUBUR, SUBUI, SUBSI};
  assign is_cmp = iw_opc inside {CMPUR, CMPUI, CMPSI};
  assign is_and = iw_opc inside {ANDUR, ANDUI};
  assign is_or  = iw_opc inside {ORUR, ORUI};
  assign is_xor = iw_opc inside {XORUR, XORUI};
  assign is_not = iw_opc == NOTUR;
  assign is_jcc = iw_opc inside {JCCUI, JCCSI};
  assign is_adda = iw_opc == ADDASI;
  assign arith = is_add | is_sub | is_cmp;
  assign fl_set = arith | is_and | is_or | is_xor;
  assign op_a = iw_tgt_gp_val;
  assign op_b = !iw_imm_en ? iw_src_gp_val :
                iw_sgn_en ? {{12{iw_imm12_val[11]}}, iw_imm12_val} : {12'b0, iw_imm12_val};
  // bit 24 is carry-out for add and borrow (A<B unsigned) for subtract
  assign sum = is_add ? {1'b0, op_a} + {1'b0, op_b} : {1'b0, op_a} - {1'b0, op_b};
  assign res = is_mov ? op_b : is_not ? ~op_a : arith ? sum[23:0] :
               is_and ? op_a & op_b : is_or ? op_a | op_b : is_xor ? op_a ^ op_b : '0;
  assign c = arith & sum[24];
  assign v = is_add ? (op_a[23] == op_b[23]) & (sum[23] != op_a[23]) :
             (is_sub | is_cmp) & (op_a[23] != op_b[23]) & (sum[23] != op_a[23]);
  assign fl_new = {v, c, res[23], ~|res};
  assign fl_in = iw_src_sr == FL ? iw_src_sr_val[3:0] : r_fl;
  assign cond = iw_cc == RA ? 1'b1 : iw_cc == EQ ? fl_in[0] : iw_cc == NE ? ~fl_in[0] :
                iw_cc == LT ? fl_in[1] ^ fl_in[3] : iw_cc == GE ? ~(fl_in[1] ^ fl_in[3]) :
                iw_cc == LTU ? fl_in[2] : iw_cc == GEU ? ~fl_in[2] : 1'b0;
  assign r_branch_taken = is_jcc & cond;
  assign br_pc = iw_opc == JCCUI ? {iw_pc[47:12], iw_imm12_val} :
                 iw_pc + {{36{iw_imm12_val[11]}}, iw_imm12_val};
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_fl <= '0;
      ow_pc <= '0;
      ow_instr <= '0;
      ow_opc <= '0;
      ow_tgt_gp <= '0;
      ow_tgt_gp_we <= 1'b0;
      ow_tgt_sr <= '0;
      ow_tgt_sr_we <= 1'b0;
      ow_tgt_ar <= '0;
      ow_tgt_ar_we <= 1'b0;
      ow_addr <= '0;
      ow_result <= '0;
      ow_ar_result <= '0;
      ow_sr_result <= '0;
      ow_branch_taken <= 1'b0;
      ow_branch_pc <= '0;
    end else if (!iw_stall) begin
      if (iw_flush) begin
        ow_opc <= NOP;
        ow_tgt_gp_we <= 1'b0;
        ow_tgt_sr_we <= 1'b0;
        ow_tgt_ar_we <= 1'b0;
        ow_branch_taken <= 1'b0;
      end else begin
        r_fl <= fl_set ? fl_new : r_fl;
        ow_pc <= iw_pc;
        ow_instr <= iw_instr;
        ow_opc <= iw_opc;
        ow_tgt_gp <= iw_tgt_gp;
        ow_tgt_gp_we <= is_cmp ? 1'b0 : iw_tgt_gp_we;
        ow_tgt_sr <= fl_set ? FL : iw_tgt_sr;
        ow_tgt_sr_we <= fl_set | iw_tgt_sr_we;
        ow_sr_result <= fl_set ? {44'b0, fl_new} : iw_tgt_sr_val;
        ow_tgt_ar <= iw_tgt_ar;
        ow_tgt_ar_we <= is_adda;
        ow_addr <= iw_src_ar_val + {{38{iw_imm10_val[9]}}, iw_imm10_val};
        ow_ar_result <= is_adda ? iw_tgt_ar_val + {{34{iw_imm14_val[13]}}, iw_imm14_val} : iw_src_ar_val;
        ow_result <= res;
        ow_branch_taken <= r_branch_taken;
        ow_branch_pc <= br_pc;
      end
    end
  end
endmodule

// File: tb/tb_stg_ex_unit.sv
// tb_stg_ex_unit: directed and random checks of stg_ex_unit against an
// arithmetic reference model of the execute stage.
module tb_stg_ex_unit;
  localparam logic [7:0] NOP = 8'h00, MOVUR = 8'h01, MOVUI = 8'h02, MOVSI = 8'h03,
    ADDUR = 8'h04, ADDUI = 8'h05, ADDSI = 8'h06, SUBUR = 8'h07, SUBUI = 8'h08, SUBSI = 8'h09,
    ANDUR = 8'h0a, ANDUI = 8'h0b, ORUR = 8'h0c, ORUI = 8'h0d, XORUR = 8'h0e, XORUI = 8'h0f,
    NOTUR = 8'h10, CMPUR = 8'h11, CMPUI = 8'h12, CMPSI = 8'h13, JCCUI = 8'h14, JCCSI = 8'h15,
    ADDASI = 8'h16;
  logic        iw_clk = 0, iw_rst = 0;
  logic [47:0] iw_pc, iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val;
  logic [23:0] iw_instr, iw_src_gp_val, iw_tgt_gp_val;
  logic [7:0]  iw_opc;
  logic        iw_sgn_en, iw_imm_en, iw_tgt_gp_we, iw_tgt_sr_we, iw_flush, iw_stall;
  logic [13:0] iw_imm14_val;
  logic [11:0] iw_imm12_val;
  logic [9:0]  iw_imm10_val;
  logic [15:0] iw_imm16_val;
  logic [3:0]  iw_cc, iw_tgt_gp, iw_src_gp;
  logic [1:0]  iw_tgt_sr, iw_tgt_ar, iw_src_ar, iw_src_sr;
  logic [47:0] ow_pc, ow_addr, ow_ar_result, ow_sr_result, ow_branch_pc;
  logic [23:0] ow_instr, ow_result;
  logic [7:0]  ow_opc;
  logic [3:0]  ow_tgt_gp;
  logic [1:0]  ow_tgt_sr, ow_tgt_ar;
  logic        ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we, ow_branch_taken;
  int total = 0, bad = 0;
  logic [3:0]  m_fl;
  logic [47:0] e_pc, e_addr, e_ar_result, e_sr_result, e_bpc;
  logic [23:0] e_instr, e_result;
  logic [7:0]  e_opc;
  logic [3:0]  e_tgt_gp;
  logic [1:0]  e_tgt_sr, e_tgt_ar;
  logic        e_gp_we, e_sr_we, e_ar_we, e_taken, e_alu, e_jcc, partial;
  logic [7:0]  ops [23] = '{NOP, MOVUR, MOVUI, MOVSI, ADDUR, ADDUI, ADDSI, SUBUR, SUBUI, SUBSI,
    ANDUR, ANDUI, ORUR, ORUI, XORUR, XORUI, NOTUR, CMPUR, CMPUI, CMPSI, JCCUI, JCCSI, ADDASI};
  logic [23:0] specials [5] = '{24'h000000, 24'hffffff, 24'h800000, 24'h7fffff, 24'h000001};

  stg_ex_unit dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
    .iw_sgn_en(iw_sgn_en), .iw_imm_en(iw_imm_en), .iw_imm14_val(iw_imm14_val),
    .iw_imm12_val(iw_imm12_val), .iw_imm10_val(iw_imm10_val), .iw_imm16_val(iw_imm16_val),
    .iw_cc(iw_cc), .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we), .iw_tgt_sr(iw_tgt_sr),
    .iw_tgt_sr_we(iw_tgt_sr_we), .iw_tgt_ar(iw_tgt_ar), .iw_src_gp(iw_src_gp),
    .iw_src_ar(iw_src_ar), .iw_src_sr(iw_src_sr), .iw_src_gp_val(iw_src_gp_val),
    .iw_tgt_gp_val(iw_tgt_gp_val), .iw_src_ar_val(iw_src_ar_val), .iw_tgt_ar_val(iw_tgt_ar_val),
    .iw_src_sr_val(iw_src_sr_val), .iw_tgt_sr_val(iw_tgt_sr_val), .iw_flush(iw_flush),
    .iw_stall(iw_stall), .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc),
    .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we), .ow_tgt_sr(ow_tgt_sr),
    .ow_tgt_sr_we(ow_tgt_sr_we), .ow_tgt_ar(ow_tgt_ar), .ow_tgt_ar_we(ow_tgt_ar_we),
    .ow_addr(ow_addr), .ow_result(ow_result), .ow_ar_result(ow_ar_result),
    .ow_sr_result(ow_sr_result), .ow_branch_taken(ow_branch_taken), .ow_branch_pc(ow_branch_pc)
  );

  always #5 iw_clk = ~iw_clk;

  function automatic longint sext(longint v, int bits);
    return v >= (longint'(1) << (bits - 1)) ? v - (longint'(1) << bits) : v;
  endfunction

  function automatic bit ovf24(longint s);
    return s > 8388607 || s < -8388608;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_in();
    {iw_pc, iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val} = '0;
    {iw_instr, iw_src_gp_val, iw_tgt_gp_val, iw_opc, iw_sgn_en, iw_imm_en} = '0;
    {iw_imm14_val, iw_imm12_val, iw_imm10_val, iw_imm16_val, iw_cc, iw_tgt_gp, iw_src_gp} = '0;
    {iw_tgt_gp_we, iw_tgt_sr_we, iw_flush, iw_stall, iw_tgt_sr, iw_tgt_ar, iw_src_ar, iw_src_sr} = '0;
  endtask

  task automatic rand_in();
    iw_pc = {$urandom, $urandom}; iw_src_ar_val = {$urandom, $urandom};
    iw_tgt_ar_val = {$urandom, $urandom}; iw_src_sr_val = {$urandom, $urandom};
    iw_tgt_sr_val = {$urandom, $urandom}; iw_instr = 24'($urandom);
    iw_src_gp_val = $urandom_range(0, 3) == 0 ? specials[$urandom_range(0, 4)] : 24'($urandom);
    iw_tgt_gp_val = $urandom_range(0, 3) == 0 ? specials[$urandom_range(0, 4)] : 24'($urandom);
    iw_opc = ops[$urandom_range(0, 22)]; iw_sgn_en = 1'($urandom); iw_imm_en = 1'($urandom);
    iw_imm14_val = 14'($urandom); iw_imm12_val = 12'($urandom); iw_imm10_val = 10'($urandom);
    iw_imm16_val = 16'($urandom); iw_cc = 4'($urandom_range(0, 7)); iw_tgt_gp = 4'($urandom);
    iw_src_gp = 4'($urandom); iw_tgt_gp_we = 1'($urandom); iw_tgt_sr_we = 1'($urandom);
    iw_tgt_sr = 2'($urandom); iw_tgt_ar = 2'($urandom); iw_src_ar = 2'($urandom);
    iw_src_sr = 2'($urandom); iw_flush = 0; iw_stall = 0;
  endtask

  task automatic model_reset();
    m_fl = 0; partial = 0; e_alu = 1; e_jcc = 1;
    {e_pc, e_addr, e_ar_result, e_sr_result, e_bpc, e_instr, e_result, e_opc} = '0;
    {e_tgt_gp, e_tgt_sr, e_tgt_ar, e_gp_we, e_sr_we, e_ar_we, e_taken} = '0;
  endtask

  // reference: what the stage must present after the next edge for the current inputs
  task automatic predict();
    logic [23:0] a, b, r;
    logic [3:0] fl;
    longint s, sv;
    bit fs, c, v, cond;
    if (iw_stall) return;
    if (iw_flush) begin
      {e_gp_we, e_sr_we, e_ar_we, e_taken} = '0;
      e_opc = NOP; partial = 1;
      return;
    end
    partial = 0;
    a = iw_tgt_gp_val;
    b = !iw_imm_en ? iw_src_gp_val :
        iw_sgn_en ? 24'(sext(longint'(iw_imm12_val), 12)) : 24'(iw_imm12_val);
    r = 0; fs = 0; c = 0; v = 0; e_alu = 1;
    case (iw_opc)
      MOVUR, MOVUI, MOVSI: r = b;
      ADDUR, ADDUI, ADDSI: begin
        s = longint'(a) + longint'(b); r = 24'(s); fs = 1; c = s >= 64'd16777216;
        sv = sext(longint'(a), 24) + sext(longint'(b), 24); v = ovf24(sv);
      end
      SUBUR, SUBUI, SUBSI, CMPUR, CMPUI, CMPSI: begin
        r = 24'(longint'(a) - longint'(b)); fs = 1; c = a < b;
        sv = sext(longint'(a), 24) - sext(longint'(b), 24); v = ovf24(sv);
      end
      ANDUR, ANDUI: begin r = a & b; fs = 1; end
      ORUR, ORUI:   begin r = a | b; fs = 1; end
      XORUR, XORUI: begin r = a ^ b; fs = 1; end
      NOTUR: r = ~a;
      default: e_alu = 0;
    endcase
    fl = iw_src_sr == 2 ? iw_src_sr_val[3:0] : m_fl;
    case (iw_cc)
      0: cond = 1;
      1: cond = fl[0];
      2: cond = !fl[0];
      3: cond = fl[1] != fl[3];
      4: cond = fl[1] == fl[3];
      5: cond = fl[2];
      6: cond = !fl[2];
      default: cond = 0;
    endcase
    e_jcc = iw_opc == JCCUI || iw_opc == JCCSI;
    e_taken = e_jcc && cond;
    e_bpc = iw_opc == JCCUI ? ((iw_pc & ~48'hfff) | 48'(iw_imm12_val)) :
            48'(longint'(iw_pc) + sext(longint'(iw_imm12_val), 12));
    e_result = r;
    e_gp_we = iw_opc inside {CMPUR, CMPUI, CMPSI} ? 0 : iw_tgt_gp_we;
    if (fs) m_fl = {v, c, r[23], r == 0};
    e_sr_we = fs ? 1 : iw_tgt_sr_we;
    e_tgt_sr = fs ? 2 : iw_tgt_sr;
    e_sr_result = fs ? 48'(m_fl) : iw_tgt_sr_val;
    e_addr = 48'(longint'(iw_src_ar_val) + sext(longint'(iw_imm10_val), 10));
    e_ar_we = iw_opc == ADDASI;
    e_ar_result = e_ar_we ? 48'(longint'(iw_tgt_ar_val) + sext(longint'(iw_imm14_val), 14)) : iw_src_ar_val;
    e_pc = iw_pc; e_instr = iw_instr; e_opc = iw_opc; e_tgt_gp = iw_tgt_gp; e_tgt_ar = iw_tgt_ar;
  endtask

  task automatic check_all();
    chk("opc", ow_opc, e_opc);
    chk("taken", ow_branch_taken, e_taken);
    chk("sr_we", ow_tgt_sr_we, e_sr_we);
    chk("ar_we", ow_tgt_ar_we, e_ar_we);
    if (partial || e_alu) chk("gp_we", ow_tgt_gp_we, e_gp_we);
    if (!partial) begin
      chk("pc", ow_pc, e_pc);
      chk("instr", ow_instr, e_instr);
      chk("tgt_gp", ow_tgt_gp, e_tgt_gp);
      chk("tgt_ar", ow_tgt_ar, e_tgt_ar);
      chk("tgt_sr", ow_tgt_sr, e_tgt_sr);
      chk("sr_result", ow_sr_result, e_sr_result);
      chk("addr", ow_addr, e_addr);
      chk("ar_result", ow_ar_result, e_ar_result);
      if (e_alu) chk("result", ow_result, e_result);
      if (e_jcc) chk("branch_pc", ow_branch_pc, e_bpc);
    end
  endtask

  task automatic step();
    predict();
    @(posedge iw_clk);
    #1;
    check_all();
  endtask

  function automatic bit any_out();
    return |{ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we, ow_tgt_ar,
             ow_tgt_ar_we, ow_addr, ow_result, ow_ar_result, ow_sr_result, ow_branch_taken, ow_branch_pc};
  endfunction

  initial begin
    zero_in();
    model_reset();
    repeat (2) @(posedge iw_clk);
    #1;
    chk("reset_outputs", any_out(), 0);
    @(negedge iw_clk);
    iw_rst = 1;
    // ADD wrap: FFFFFF + 1 -> 0 with carry
    iw_opc = ADDUR; iw_tgt_gp_val = 24'hffffff; iw_src_gp_val = 24'h000001; iw_tgt_gp_we = 1;
    step();
    chk("add_wrap_result", ow_result, 24'h0);
    chk("add_wrap_flags", ow_sr_result[3:0], 4'b0101);
    chk("add_wrap_tgt_sr", ow_tgt_sr, 2);
    // JCCui EQ with flags sourced from the SR operand
    zero_in();
    iw_opc = JCCUI; iw_cc = 1; iw_src_sr = 2; iw_src_sr_val = 48'h1; iw_imm12_val = 12'h123;
    step();
    chk("jcc_eq_taken", ow_branch_taken, 1);
    chk("jcc_eq_pc", ow_branch_pc, 48'h000000000123);
    // SUB 0-1 then a LTU branch that reads the stored flags
    zero_in();
    iw_opc = SUBUR; iw_tgt_gp_val = 0; iw_src_gp_val = 1; iw_tgt_gp_we = 1;
    step();
    chk("sub_result", ow_result, 24'hffffff);
    chk("sub_flags", ow_sr_result[3:0], 4'b0110);
    zero_in();
    iw_opc = JCCSI; iw_cc = 5; iw_pc = 48'h1000; iw_imm12_val = 12'hff0;
    step();
    chk("jcc_ltu_taken", ow_branch_taken, 1);
    chk("jcc_si_pc", ow_branch_pc, 48'h000000000ff0);
    iw_cc = 7; iw_src_sr = 2; iw_src_sr_val = 48'hf;
    step();
    chk("jcc_undef", ow_branch_taken, 0);
    // CMP keeps GP writeback off, ADDA writes AR
    zero_in();
    iw_opc = CMPSI; iw_imm_en = 1; iw_sgn_en = 1; iw_imm12_val = 12'hfff; iw_tgt_gp_val = 24'hffffff;
    iw_tgt_gp_we = 1;
    step();
    chk("cmp_gp_we", ow_tgt_gp_we, 0);
    chk("cmp_flags", ow_sr_result[3:0], 4'b0001);
    zero_in();
    iw_opc = ADDASI; iw_tgt_ar_val = 48'h10; iw_imm14_val = 14'h3ffe; iw_src_ar_val = 48'h100;
    iw_imm10_val = 10'h3ff;
    step();
    chk("adda_result", ow_ar_result, 48'he);
    chk("adda_addr", ow_addr, 48'hff);
    // stall holds, flush bubbles, stall beats flush
    rand_in(); iw_opc = ADDUR; iw_stall = 1;
    step();
    rand_in(); iw_opc = ORUR; iw_flush = 1; iw_tgt_gp_we = 1; iw_tgt_sr_we = 1;
    step();
    chk("flush_opc", ow_opc, NOP);
    rand_in(); iw_stall = 1; iw_flush = 1;
    step();
    for (int i = 0; i < 400; i++) begin
      rand_in();
      iw_stall = $urandom_range(0, 9) == 0;
      iw_flush = $urandom_range(0, 9) == 0;
      step();
    end
    // asynchronous reset in the middle of a cycle
    rand_in(); iw_opc = ADDUR; iw_tgt_gp_we = 1;
    step();
    #2 iw_rst = 0;
    #1 chk("async_reset", any_out(), 0);
    model_reset();
    #3 iw_rst = 1;
    for (int i = 0; i < 100; i++) begin
      rand_in();
      iw_stall = $urandom_range(0, 9) == 0;
      iw_flush = $urandom_range(0, 9) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
